// File: rtl/rf_dbg_pkg.sv
// Shared types and defaults for the register-file debug access engine.
package rf_dbg_pkg;

    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;

    localparam logic MODE_DUMP = 1'b0;
    localparam logic MODE_LOAD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT_WAIT,
        ST_DUMP,
        ST_DRAIN,
        ST_LOAD,
        ST_DONE
    } dbg_state_t;

endpackage

// File: rtl/rf_dbg_out_reg.sv
// One-entry valid/ready output stage holding a dumped register value and its index.
module rf_dbg_out_reg #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_idx,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] idx
);

    // Capture a new beat, drop a consumed one; clear wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            idx   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            idx   <= load_idx;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_debug_port.sv
// Debug access engine: halts the core, then dumps or loads the whole register file.
module rf_debug_port
    import rf_dbg_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic              core_halt,
    input  logic              core_halted,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    // One extra bit so the walk index can never wrap inside an operation.
    localparam int IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    dbg_state_t       state;
    dbg_state_t       state_next;
    logic [IDX_W-1:0] idx;
    logic             mode_q;
    logic             capture;
    logic             accept;
    logic             idx_last;

    assign idx_last = (idx == LAST_IDX);
    assign accept   = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (start) state_next = ST_HALT_WAIT;
            ST_HALT_WAIT: if (core_halted) state_next = (mode_q == MODE_LOAD) ? ST_LOAD : ST_DUMP;
            ST_DUMP:      if (capture && idx_last) state_next = ST_DRAIN;
            ST_DRAIN:     if (out_valid && out_ready) state_next = ST_DONE;
            ST_LOAD:      if (accept && idx_last) state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
        if (abort) state_next = ST_IDLE;
    end

    // Output decode: port ownership, stream handshakes, register-file controls.
    always_comb begin
        core_halt  = (state != ST_IDLE);
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        in_ready   = (state == ST_LOAD) && !abort;
        capture    = (state == ST_DUMP) && (!out_valid || out_ready) && !abort;
        rf_rd_addr = '0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (state == ST_DUMP) begin
            rf_rd_addr = idx[ADDR_W-1:0];
        end
        if (state == ST_LOAD) begin
            rf_wr_addr = idx[ADDR_W-1:0];
            rf_wr_data = in_data;
            // x0 is hardwired: its beat is consumed but never written.
            rf_wr_en   = in_valid && !abort && (idx != '0);
        end
    end

    // Walk index and latched command mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            mode_q <= MODE_DUMP;
        end else if (abort) begin
            idx <= '0;
        end else if (state == ST_IDLE && start) begin
            idx    <= '0;
            mode_q <= mode;
        end else if (capture || accept) begin
            idx <= idx + IDX_W'(1);
        end
    end

    rf_dbg_out_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort),
        .load      (capture),
        .load_data (rf_rd_data),
        .load_idx  (idx[ADDR_W-1:0]),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .idx       (out_idx)
    );

endmodule

// File: tb/tb_rf_debug_port.sv
// Self-checking bench for rf_debug_port with a register-file model and scoreboards.
module tb_rf_debug_port;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic          ack_en = 1'b1;
    logic          core_halt;
    logic          core_halted;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;

    typedef struct {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_out[$];
    beat_t exp_wr[$];
    int    n_checks = 0;
    int    n_fail = 0;

    logic [DW-1:0] rf [64] = '{default: '0};

    always #5 clk = ~clk;

    assign core_halted = ack_en & core_halt;
    assign rf_rd_data  = rf[rf_rd_addr];

    always @(posedge clk) begin
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    rf_debug_port #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .NUM_REGS(NR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .abort       (abort),
        .core_halt   (core_halt),
        .core_halted (core_halted),
        .busy        (busy),
        .done        (done),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    // Output-stream and write-port monitors, sampled away from the clock edge.
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic [AW-1:0] held_i = '0;

    always @(negedge clk) begin
        beat_t e;
        if (held_v && out_valid) begin
            check("stall_data", out_data, held_d);
            check("stall_idx", 64'(out_idx), 64'(held_i));
        end
        held_v = out_valid && !out_ready;
        held_d = out_data;
        held_i = out_idx;
        if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
                check("out_unexpected", 64'd1, 64'd0);
            end else begin
                e = exp_out.pop_front();
                check("out_idx", 64'(out_idx), 64'(e.idx));
                check("out_data", out_data, e.data);
            end
        end
        if (rf_wr_en) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 64'(rf_wr_addr), 64'hFFFF);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(rf_wr_addr), 64'(e.idx));
                check("wr_data", rf_wr_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic push_dump(input int upto);
        for (int i = 0; i <= upto; i++) begin
            beat_t b;
            b.idx  = AW'(i);
            b.data = (i == 0) ? 64'd0 : 64'(1000 + i);
            exp_out.push_back(b);
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                return;
            end
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_load(input int base, input int stop);
        int   k = 0;
        int   guard = 0;
        logic hs;
        in_valid = 1'b1;
        in_data  = 64'(base);
        pulse_start(1'b1);
        while (k < stop && guard < 200) begin
            @(negedge clk);
            hs = in_ready;
            step();
            if (hs) begin
                k++;
                if (k < stop) begin
                    beat_t b;
                    in_data = 64'(base + k);
                    b.idx   = AW'(k);
                    b.data  = 64'(base + k);
                    exp_wr.push_back(b);
                end
            end
            guard++;
        end
        if (guard >= 200) check("load_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_core_halt", 64'(core_halt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
        check("rst_wr_addr", 64'(rf_wr_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic found;
        logic got_done;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        step();

        // Preload x1..x31 = 1000+i
        run_load(1000, 32);
        in_valid = 1'b0;
        @(negedge clk);
        check("load_done", 64'(done), 64'd1);
        step();
        @(negedge clk);
        check("load_done_pulse", 64'(done), 64'd0);
        check("load_idle_halt", 64'(core_halt), 64'd0);
        check("load_idle_busy", 64'(busy), 64'd0);
        check("load_wr_left", 64'(exp_wr.size()), 64'd0);
        check("rf_x0", rf[0], 64'd0);
        for (int i = 1; i < NR; i++) check("rf_load", rf[i], 64'(1000 + i));
        step();

        // Full-rate dump and latency
        out_ready = 1'b1;
        push_dump(NR - 1);
        pulse_start(1'b0);
        wait_done(100, cyc);
        check("dump_latency", 64'(cyc), 64'(NR + 3));
        check("dump_left", 64'(exp_out.size()), 64'd0);
        step();

        // Dump with backpressure pattern 1,0,0
        push_dump(NR - 1);
        pulse_start(1'b0);
        got_done = 1'b0;
        for (int c = 0; c < 400 && !got_done; c++) begin
            out_ready = (c % 3 == 0);
            @(negedge clk);
            if (done) got_done = 1'b1;
            step();
        end
        check("stall_done", 64'(got_done), 64'd1);
        check("stall_left", 64'(exp_out.size()), 64'd0);
        out_ready = 1'b1;

        // Halt acknowledge delayed 5 cycles
        ack_en = 1'b0;
        push_dump(NR - 1);
        pulse_start(1'b0);
        repeat (5) begin
            @(negedge clk);
            check("wait_busy", 64'(busy), 64'd1);
            check("wait_halt", 64'(core_halt), 64'd1);
            check("wait_out_valid", 64'(out_valid), 64'd0);
            check("wait_wr_en", 64'(rf_wr_en), 64'd0);
            check("wait_rd_addr", 64'(rf_rd_addr), 64'd0);
            step();
        end
        ack_en = 1'b1;
        wait_done(100, cyc);
        check("wait_left", 64'(exp_out.size()), 64'd0);
        step();

        // Abort during dump at idx 10, then a normal dump
        push_dump(10);
        pulse_start(1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_idx == AW'(10)) found = 1'b1;
        end
        check("abort_reach_idx10", 64'(found), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_halt", 64'(core_halt), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        check("abort_left", 64'(exp_out.size()), 64'd0);
        step();
        push_dump(NR - 1);
        pulse_start(1'b0);
        wait_done(100, cyc);
        check("restart_latency", 64'(cyc), 64'(NR + 3));
        check("restart_left", 64'(exp_out.size()), 64'd0);
        step();

        // Reset asserted mid-load when idx reaches 7
        run_load(2000, 7);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < 7; i++) check("rf_partial", rf[i], 64'(2000 + i));
        check("rf_x7_kept", rf[7], 64'd1007);
        check("rf_x0_kept", rf[0], 64'd0);
        check("partial_wr_left", 64'(exp_wr.size()), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
